// File: rtl/spi_duty_rx_if.sv
// SPI pin bundle between the host (master) and spi_duty_rx (slave).
// Signals: sck, cs_n, mosi driven by the master; miso driven by the slave.
interface spi_duty_rx_if;
    logic sck;
    logic cs_n;
    logic mosi;
    logic miso;

    modport master (
        output sck,
        output cs_n,
        output mosi,
        input  miso
    );

    modport slave (
        input  sck,
        input  cs_n,
        input  mosi,
        output miso
    );
endinterface

// File: rtl/spi_duty_rx.sv
// SPI mode-0 slave receiving 8-bit duty commands for the PWM stage.
// Ports: SLK, rst_n (async, active low), spi (slave modport: sck, cs_n,
//   mosi, miso), Porcentaje (registered duty), duty_valid, frame_err pulses.
// Optional macro SPI_WDOG_EN adds a watchdog that zeroes the duty value
//   after WDOG_CYCLES SLK cycles without a CMD_SET commit.
module spi_duty_rx #(
    parameter logic [3:0]  MAX_DUTY    = 4'd9,
    parameter logic [3:0]  CMD_SET     = 4'hA,
    parameter logic [23:0] WDOG_CYCLES = 24'd5000000
) (
    input  logic         SLK,
    input  logic         rst_n,
    spi_duty_rx_if.slave spi,
    output logic [3:0]   Porcentaje,
    output logic         duty_valid,
    output logic         frame_err
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t     state;
    logic [2:0] sck_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] tx;
    logic       armed;

    logic       sck_rise;
    logic       sck_fall;
    logic       cs_s;
    logic       mosi_s;
    logic [3:0] cmd;
    logic [3:0] val;
    logic       is_set;
    logic       is_err;
    logic [3:0] new_duty;
    logic [7:0] tx_load;

    // Stage [1] is the synchronised level, stage [2] its history.
    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign cs_s     = cs_q[1];
    assign mosi_s   = mosi_q[1];

    assign cmd      = shreg[7:4];
    assign val      = shreg[3:0];
    assign is_set   = (cmd == CMD_SET);
    assign is_err   = (cmd != CMD_SET) && (cmd != 4'h0);

    always_comb begin
        new_duty = Porcentaje;
        if (is_set) begin
            new_duty = (val > MAX_DUTY) ? MAX_DUTY : val;
        end
    end

    // Status byte for the next frame reflects the duty after this commit.
    assign tx_load = {4'h5, (state == COMMIT) ? new_duty : Porcentaje};

`ifdef SPI_WDOG_EN
    logic [23:0] wd_cnt;
    logic        wd_fire;
    assign wd_fire = (wd_cnt == WDOG_CYCLES - 24'd1);
`endif

    always_ff @(posedge SLK or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sck_q      <= '0;
            cs_q       <= '0;
            mosi_q     <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            tx         <= '0;
            armed      <= 1'b0;
            Porcentaje <= '0;
            duty_valid <= 1'b0;
            frame_err  <= 1'b0;
            spi.miso   <= 1'b0;
`ifdef SPI_WDOG_EN
            wd_cnt     <= '0;
`endif
        end else begin
            sck_q      <= {sck_q[1:0], spi.sck};
            cs_q       <= {cs_q[1:0], spi.cs_n};
            mosi_q     <= {mosi_q[0], spi.mosi};
            duty_valid <= 1'b0;
            frame_err  <= 1'b0;

            // A frame may only start once cs_n has been seen high.
            if (cs_s) begin
                armed <= 1'b1;
            end

`ifdef SPI_WDOG_EN
            wd_cnt <= wd_fire ? 24'd0 : wd_cnt + 24'd1;
            if (wd_fire) begin
                Porcentaje <= '0;
                frame_err  <= 1'b1;
            end
`endif

            unique case (state)
                IDLE: begin
                    bit_cnt  <= '0;
                    spi.miso <= 1'b0;
                    if (armed && !cs_s) begin
                        state    <= SHIFT;
                        tx       <= tx_load;
                        spi.miso <= tx_load[7];
                    end
                end
                SHIFT: begin
                    // The 8th rise commits even if cs_n rises alongside it.
                    if (sck_rise) begin
                        shreg   <= {shreg[6:0], mosi_s};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= COMMIT;
                        end
                    end else if (cs_s) begin
                        state    <= IDLE;
                        bit_cnt  <= '0;
                        shreg    <= '0;
                        spi.miso <= 1'b0;
                        if (bit_cnt != 3'd0) begin
                            frame_err <= 1'b1;
                        end
                    end else if (sck_fall && bit_cnt != 3'd0) begin
                        // The fall after bit 8 must not eat the reloaded MSB.
                        tx       <= {tx[6:0], 1'b0};
                        spi.miso <= tx[6];
                    end
                end
                COMMIT: begin
                    if (is_set) begin
                        Porcentaje <= new_duty;
                        duty_valid <= 1'b1;
`ifdef SPI_WDOG_EN
                        wd_cnt     <= '0;
`endif
                    end
                    if (is_err) begin
                        frame_err <= 1'b1;
                    end
                    tx <= tx_load;
                    if (cs_s) begin
                        state    <= IDLE;
                        spi.miso <= 1'b0;
                    end else begin
                        state    <= SHIFT;
                        spi.miso <= tx_load[7];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_duty_rx.sv
// Self-checking bench for spi_duty_rx: directed and random SPI frames
// compared against a command-level model of the duty register.
module tb_spi_duty_rx;

`ifdef SPI_WDOG_EN
    localparam int WD = 2000;
`else
    localparam int WD = 100;
`endif

    logic       SLK = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] Porcentaje;
    logic       duty_valid;
    logic       frame_err;

    always #5 SLK = ~SLK;

    spi_duty_rx_if bus ();

    spi_duty_rx #(
        .MAX_DUTY    (4'd9),
        .CMD_SET     (4'hA),
        .WDOG_CYCLES (24'(WD))
    ) dut (
        .SLK        (SLK),
        .rst_n      (rst_n),
        .spi        (bus.slave),
        .Porcentaje (Porcentaje),
        .duty_valid (duty_valid),
        .frame_err  (frame_err)
    );

    int checks = 0;
    int passed = 0;
    int dv_cnt = 0;
    int fe_cnt = 0;
    int exp_dv = 0;
    int exp_fe = 0;
    logic [3:0] mdl = 4'd0;

    always @(negedge SLK) begin
        if (duty_valid === 1'b1) dv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge SLK);
        #2;
    endtask

    // Command-level model: returns whether the frame loads a duty value.
    task automatic model_frame(input logic [7:0] b, output bit set);
        logic [3:0] c;
        logic [3:0] v;
        c = b[7:4];
        v = b[3:0];
        set = (c == 4'hA);
        if (set) begin
            mdl = (v > 4'd9) ? 4'd9 : v;
            exp_dv++;
        end else if (c != 4'h0) begin
            exp_fe++;
        end
    endtask

    task automatic bit_xfer(input logic b, output logic m,
                            input bit last, input bit exp_set);
        @(negedge SLK);
        bus.mosi = b;
        repeat (4) @(negedge SLK);
        m = bus.miso;
        bus.sck = 1'b1;
        if (last) begin
            repeat (3) @(posedge SLK);
            @(negedge SLK);
            chk("lat_pre", {31'd0, duty_valid}, 32'd0);
            @(negedge SLK);
            chk("lat_dv", {31'd0, duty_valid}, {31'd0, exp_set});
            repeat (6) @(negedge SLK);
        end else begin
            repeat (8) @(negedge SLK);
        end
        bus.sck = 1'b0;
        repeat (4) @(negedge SLK);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n,
                             output logic [7:0] m, input bit exp_set);
        logic mb;
        m = 8'h00;
        for (int i = 0; i < n; i++) begin
            bit_xfer(b[7-i], mb, (i == 7), exp_set);
            m[7-i] = mb;
        end
    endtask

    task automatic cs_low();
        bus.cs_n = 1'b0;
        repeat (8) @(negedge SLK);
    endtask

    task automatic cs_high();
        bus.cs_n = 1'b1;
        settle(8);
        chk("miso_idle", {31'd0, bus.miso}, 32'd0);
        chk("dv_cnt", dv_cnt, exp_dv);
        chk("fe_cnt", fe_cnt, exp_fe);
    endtask

    task automatic byte_tx(input logic [7:0] b);
        logic [7:0] m;
        logic [7:0] em;
        bit         set;
        em = {4'h5, mdl};
        model_frame(b, set);
        send_bits(b, 8, m, set);
        settle(2);
        chk("miso_byte", {24'd0, m}, {24'd0, em});
        chk("duty", {28'd0, Porcentaje}, {28'd0, mdl});
    endtask

    task automatic abort_tx(input logic [7:0] b, input int n);
        logic [7:0] m;
        cs_low();
        send_bits(b, n, m, 1'b0);
        exp_fe++;
        cs_high();
        chk("abort_duty", {28'd0, Porcentaje}, {28'd0, mdl});
    endtask

    initial begin
        logic [7:0] m;
        logic [7:0] b;
        bus.sck  = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;

        settle(4);
        chk("rst_duty", {28'd0, Porcentaje}, 32'd0);
        chk("rst_dv", {31'd0, duty_valid}, 32'd0);
        chk("rst_fe", {31'd0, frame_err}, 32'd0);
        chk("rst_miso", {31'd0, bus.miso}, 32'd0);
        rst_n = 1'b1;
        settle(8);

        cs_low();
        byte_tx(8'hA6);
        cs_high();

        cs_low();
        byte_tx(8'hAF);
        byte_tx(8'h03);
        cs_high();

        cs_low();
        byte_tx(8'h77);
        cs_high();

        abort_tx(8'hA2, 5);
        cs_low();
        byte_tx(8'hA2);
        cs_high();

        // Reset mid-frame, then a frame without a prior cs_n high is ignored.
        cs_low();
        send_bits(8'hA8, 4, m, 1'b0);
        @(negedge SLK);
        rst_n = 1'b0;
        #1;
        chk("async_rst", {28'd0, Porcentaje}, 32'd0);
        mdl = 4'd0;
        settle(4);
        rst_n = 1'b1;
        settle(8);
        send_bits(8'hA3, 8, m, 1'b0);
        settle(2);
        chk("unarmed_duty", {28'd0, Porcentaje}, 32'd0);
        chk("unarmed_miso", {24'd0, m}, 32'd0);
        cs_high();
        cs_low();
        byte_tx(8'hA8);
        cs_high();

        for (int i = 0; i < 16; i++) begin
            int r;
            r = (i % 4 == 3) ? 0 : int'($urandom_range(0, 3));
            b = 8'($urandom);
            case (r)
                0: b[7:4] = 4'hA;
                1: b[7:4] = 4'h0;
                default: ;
            endcase
            if (r == 3) begin
                abort_tx(b, int'($urandom_range(1, 7)));
            end else begin
                cs_low();
                byte_tx(b);
                cs_high();
            end
        end

        cs_low();
        byte_tx(8'hA5);
        cs_high();
        settle(WD + 20);
`ifdef SPI_WDOG_EN
        mdl = 4'd0;
        exp_fe++;
`endif
        chk("wdog_duty", {28'd0, Porcentaje}, {28'd0, mdl});
        chk("wdog_fe", fe_cnt, exp_fe);
        chk("wdog_dv", dv_cnt, exp_dv);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
